// File: rtl/fifo_uart_tx_if.sv
// Link between the byte FIFO read port, the baud strobe and the serial transmitter outputs.
interface fifo_uart_tx_if;
    logic       b_tick;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_pop;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        input  b_tick, fifo_empty, fifo_rdata,
        output fifo_pop, tx, tx_busy, tx_done
    );

    modport slave (
        output b_tick, fifo_empty, fifo_rdata,
        input  fifo_pop, tx, tx_busy, tx_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a byte FIFO, one pop per frame; PARITY_EN adds an even-parity bit.
// Start bit begins 1 clk after the pop, each bit lasts OVERSAMPLE b_ticks; waits on fifo_empty.
module fifo_uart_tx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master bus
);
    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, state_nxt;
    logic [TW-1:0]   tick, tick_nxt;
    logic [2:0]      bit_cnt, bit_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            tx_q, tx_nxt;
    logic            busy_q, busy_nxt;
    logic            done_q, done_nxt;
    logic            pop;
    logic            bit_end;

    assign bit_end = bus.b_tick && (tick == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            tick    <= tick_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
            tx_q    <= tx_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        tx_nxt    = tx_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        pop       = 1'b0;

        if (bus.b_tick) begin
            tick_nxt = bit_end ? '0 : tick + 1'b1;
        end

        case (state)
            IDLE: begin
                tick_nxt = '0;
                // rst gates the pop so a held reset can never drain the FIFO
                if (!bus.fifo_empty && !rst) begin
                    pop       = 1'b1;
                    shift_nxt = bus.fifo_rdata;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_nxt    = shift[0];
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_nxt   = bit_cnt + 3'd1;
                    // rotate rather than shift so the byte stays intact for parity
                    shift_nxt = {shift[0], shift[7:1]};
                    if (bit_cnt == 3'd7) begin
`ifdef PARITY_EN
                        tx_nxt    = ^shift;
                        state_nxt = PARITY;
`else
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
`endif
                    end else begin
                        tx_nxt = shift[1];
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_nxt    = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.fifo_pop = pop;
    assign bus.tx       = tx_q;
    assign bus.tx_busy  = busy_q;
    assign bus.tx_done  = done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx: a queue-backed FIFO, a tick-counting frame model and a line decoder.
module tb_fifo_uart_tx;
    localparam int OVS = 16;
`ifdef PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = OVS * NBITS;

    logic clk = 1'b0;
    logic rst;

    fifo_uart_tx_if bus ();

    fifo_uart_tx #(.OVERSAMPLE(OVS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] fifo_q[$];
    logic       rst_next;
    int         tick_mode;
    int         tick_period;
    int         bitlen;

    // frame model: busy flag, b_ticks counted since the pop, bits in line order
    bit               m_busy;
    bit               m_done_pend;
    int               m_ticks;
    logic [NBITS-1:0] m_bits;

    logic pop_prev;
    logic prev_tx;
    int   pops, dones;
    int   pop_cyc[$];
    int   done_cyc[$];
    int   trans[$];

    bit         rx_act;
    int         rx_t0;
    logic [7:0] rx_byte;
    logic       rx_par;
    logic [7:0] rx_q[$];
    logic       rx_par_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
        logic [NBITS-1:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [8:0] rxget(input int i);
        return (i < rx_q.size()) ? {1'b0, rx_q[i]} : 9'h100;
    endfunction

    function automatic logic [1:0] parget(input int i);
        return (i < rx_par_q.size()) ? {1'b0, rx_par_q[i]} : 2'b10;
    endfunction

    task automatic clear_log();
        pops = 0;
        dones = 0;
        pop_cyc.delete();
        done_cyc.delete();
        trans.delete();
        rx_q.delete();
        rx_par_q.delete();
    endtask

    task automatic step();
        logic exp_pop, exp_tx;
        int   off, k;
        @(posedge clk);
        #1;
        if (pop_prev && fifo_q.size() != 0) void'(fifo_q.pop_front());
        rst = rst_next;
        case (tick_mode)
            0:       bus.b_tick = 1'b1;
            1:       bus.b_tick = ((cyc % tick_period) == 0);
            default: bus.b_tick = 1'($urandom_range(1, 0));
        endcase
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
        cyc++;
        @(negedge clk);

        if (rst) begin
            m_busy      = 1'b0;
            m_done_pend = 1'b0;
            m_ticks     = 0;
            rx_act      = 1'b0;
        end
        exp_pop = !rst && !m_busy && (fifo_q.size() != 0);
        exp_tx  = m_busy ? m_bits[m_ticks / OVS] : 1'b1;
        check("outs{pop,tx,busy,done}",
              {28'd0, bus.fifo_pop, bus.tx, bus.tx_busy, bus.tx_done},
              {28'd0, exp_pop, exp_tx, m_busy, m_done_pend});

        if (bus.fifo_pop === 1'b1) begin pops++;  pop_cyc.push_back(cyc);  end
        if (bus.tx_done === 1'b1)  begin dones++; done_cyc.push_back(cyc); end
        if (bus.tx !== prev_tx) trans.push_back(cyc);

        m_done_pend = 1'b0;
        if (m_busy && bus.b_tick) begin
            m_ticks++;
            if (m_ticks == FRAME) begin
                m_busy      = 1'b0;
                m_done_pend = 1'b1;
            end
        end
        if (exp_pop) begin
            m_busy  = 1'b1;
            m_ticks = 0;
            m_bits  = frame_bits(fifo_q[0]);
        end

        // mid-bit line decoder, usable whenever the bit length is fixed
        if (bitlen > 0 && !rst) begin
            if (!rx_act) begin
                if (prev_tx === 1'b1 && bus.tx === 1'b0) begin
                    rx_act = 1'b1;
                    rx_t0  = cyc;
                end
            end else begin
                off = cyc - rx_t0;
                if ((off % bitlen) == bitlen / 2) begin
                    k = off / bitlen;
                    if (k >= 1 && k <= 8) rx_byte[k-1] = bus.tx;
                    if (k == 9 && NBITS == 11) rx_par = bus.tx;
                    if (k == NBITS - 1) begin
                        check("stop_bit", bus.tx, 1);
                        rx_q.push_back(rx_byte);
                        rx_par_q.push_back(rx_par);
                        rx_act = 1'b0;
                    end
                end
            end
        end
        pop_prev = bus.fifo_pop;
        prev_tx  = bus.tx;
    endtask

    task automatic wait_dones(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (dones < target && n < budget) begin
            step();
            n++;
        end
        check(tag, (dones >= target) ? 1 : 0, 1);
    endtask

    initial begin
        logic [7:0] b;
        int         bad, rel, d0;

        rst            = 1'b1;
        rst_next       = 1'b1;
        bus.b_tick     = 1'b1;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = 8'h00;
        tick_mode      = 0;
        tick_period    = 1;
        bitlen         = OVS;
        m_busy         = 1'b0;
        m_done_pend    = 1'b0;
        m_ticks        = 0;
        m_bits         = '1;
        pop_prev       = 1'b0;
        prev_tx        = 1'b1;
        rx_act         = 1'b0;
        rx_byte        = 8'h00;
        rx_par         = 1'b0;
        clear_log();

        // reset held with data already waiting
        fifo_q.push_back(8'h55);
        repeat (3) step();
        check("rst_pop", bus.fifo_pop, 0);
        check("rst_tx", bus.tx, 1);
        check("rst_busy", bus.tx_busy, 0);
        check("rst_done", bus.tx_done, 0);

        // single 0x55 frame, b_tick constantly high
        rst_next = 1'b0;
        wait_dones(1, FRAME + 50, "t55_timeout");
        repeat (2) step();
        check("t55_pops", pops, 1);
        check("t55_start_after_pop", qget(trans, 0) - qget(pop_cyc, 0), 1);
        check("t55_done_offset", qget(done_cyc, 0) - qget(pop_cyc, 0), FRAME + 1);
        check("t55_bit_clks", qget(trans, 2) - qget(trans, 1), OVS);
        check("t55_rx_byte", rxget(0), 9'h055);
`ifdef PARITY_EN
        check("t55_parity", parget(0), 2'b00);
`endif

        // FIFO empty: line must stay idle
        clear_log();
        bad = 0;
        repeat (50) begin
            step();
            if (bus.fifo_pop !== 1'b0 || bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
        end
        check("idle_bad_cycles", bad, 0);
        check("idle_pops", pops, 0);

        // three queued bytes back to back
        clear_log();
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'hFF);
        wait_dones(3, 3 * FRAME + 100, "burst_timeout");
        step();
        check("burst_pops", pops, 3);
        check("burst_rx0", rxget(0), 9'h0A1);
        check("burst_rx1", rxget(1), 9'h03C);
        check("burst_rx2", rxget(2), 9'h0FF);
        check("burst_pop_on_done1", qget(pop_cyc, 1), qget(done_cyc, 0));
        check("burst_pop_on_done2", qget(pop_cyc, 2), qget(done_cyc, 1));
        check("burst_frame_period", qget(pop_cyc, 1) - qget(pop_cyc, 0), FRAME + 1);

        // parity patterns
        clear_log();
        fifo_q.push_back(8'h55);
        fifo_q.push_back(8'h07);
        wait_dones(2, 2 * FRAME + 100, "par_timeout");
        step();
        check("par_rx0", rxget(0), 9'h055);
        check("par_rx1", rxget(1), 9'h007);
        check("par_done_offset", qget(done_cyc, 1) - qget(pop_cyc, 1), FRAME + 1);
`ifdef PARITY_EN
        check("par_bit_55", parget(0), 2'b00);
        check("par_bit_07", parget(1), 2'b01);
`endif

        // b_tick every 4th clk: bits stretch to 64 clks
        clear_log();
        tick_mode   = 1;
        tick_period = 4;
        bitlen      = OVS * 4;
        fifo_q.push_back(8'h55);
        wait_dones(1, FRAME * 4 + 100, "tick4_timeout");
        step();
        check("tick4_pops", pops, 1);
        check("tick4_bit1_clks", qget(trans, 2) - qget(trans, 1), OVS * 4);
        check("tick4_bit5_clks", qget(trans, 6) - qget(trans, 5), OVS * 4);
        check("tick4_rx", rxget(0), 9'h055);
        d0 = qget(done_cyc, 0) - qget(pop_cyc, 0);
        check("tick4_frame_range", (d0 >= FRAME * 4 - 2 && d0 <= FRAME * 4 + 1) ? 1 : 0, 1);

        // random strobes and random byte arrival
        clear_log();
        tick_mode = 2;
        bitlen    = 0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            fifo_q.push_back(b);
            repeat ($urandom_range(40, 0)) step();
        end
        wait_dones(5, 5 * FRAME * 4, "rand_timeout");
        step();
        check("rand_pops", pops, 5);

        // reset 40 clks into DATA of a 0x00 frame, 0x5A still queued
        clear_log();
        tick_mode = 0;
        bitlen    = OVS;
        repeat (3) step();
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'h5A);
        bad = 0;
        while (pops == 0 && bad < 20) begin
            step();
            bad++;
        end
        check("rstmid_first_pop", pops, 1);
        repeat (OVS + 1 + 40) step();
        check("rstmid_tx_before", bus.tx, 0);
        #2;
        rst      = 1'b1;
        rst_next = 1'b1;
        #1;
        check("rstmid_tx_async", bus.tx, 1);
        check("rstmid_busy_async", bus.tx_busy, 0);
        check("rstmid_pop_async", bus.fifo_pop, 0);
        repeat (2) step();
        check("rstmid_no_done", dones, 0);
        rst_next = 1'b0;
        step();
        rel = cyc;
        check("rstmid_pop_at_release", qget(pop_cyc, 1), rel);
        wait_dones(1, FRAME + 50, "rstmid_timeout");
        step();
        check("rstmid_dones", dones, 1);
        check("rstmid_rx", rxget(0), 9'h05A);
        check("rstmid_rx_count", rx_q.size(), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16, meaning b_tick pulses per transmitted bit.
REQ-002 The block SHALL have port clk, input, 1, system clock, with all state updated on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port b_tick, input, 1, single-clk baud oversample strobe.
REQ-005 The block SHALL have port fifo_empty, input, 1, empty flag from the FIFO control unit.
REQ-006 The block SHALL have port fifo_rdata, input, 8, FIFO read data; it is combinationally valid at the current read pointer.
REQ-007 The block SHALL have port fifo_pop, output, 1, one-clk pop strobe to the FIFO control unit.
REQ-008 The block SHALL have port tx, output, 1, serial line; idle level is 1.
REQ-009 The block SHALL have port tx_busy, output, 1, high while a frame is in progress.
REQ-010 The block SHALL have port tx_done, output, 1, one-clk pulse at the end of a frame.

Function
REQ-011 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; PARITY exists only per REQ-027.
REQ-012 In IDLE, when fifo_empty=0, the block SHALL assert fifo_pop for exactly one clk, latch fifo_rdata into an 8-bit shift register in the same cycle, and enter START on the next edge.
REQ-013 fifo_pop SHALL never be asserted while fifo_empty=1 or outside IDLE, so at most one pop occurs per frame.
REQ-014 The start bit SHALL drive tx=0 for OVERSAMPLE b_tick pulses, then the FSM SHALL enter DATA.
REQ-015 DATA SHALL send 8 bits LSB first, each held for OVERSAMPLE b_tick pulses, using a 3-bit bit counter that wraps 7->0 on exit.
REQ-016 The stop bit SHALL drive tx=1 for OVERSAMPLE b_tick pulses; at completion the block SHALL pulse tx_done for one clk and return to IDLE.
REQ-017 The tick counter SHALL be $clog2(OVERSAMPLE) bits wide, advance only on b_tick=1, reset to 0 at every bit boundary, and freeze while b_tick=0.
REQ-018 tx_busy SHALL be 1 from the clk after the pop through the STOP exit edge, and 0 otherwise.
REQ-019 For back-to-back frames, if fifo_empty=0 on the clk after returning to IDLE, the next pop SHALL occur then, giving exactly one idle clk (tx=1) between frames.
REQ-020 fifo_empty rising mid-frame SHALL NOT affect the current frame.
REQ-021 The tx output SHALL be registered and glitch-free; it SHALL NOT be driven combinationally from the FSM state.

Reset
REQ-022 On rst=1 the block SHALL immediately force state=IDLE, tx=1, fifo_pop=0, tx_busy=0, tx_done=0, and tick, bit and shift registers to 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame without a tx_done pulse; the popped byte is lost.
REQ-024 After rst deasserts, the first pop SHALL occur no earlier than the first clk edge that sees fifo_empty=0.

Configuration
REQ-025 The configuration macro SHALL be named PARITY_EN.
REQ-026 Without PARITY_EN, a frame SHALL be start + 8 data + stop = 10 bits, DATA SHALL go directly to STOP, and no PARITY state logic SHALL exist.
REQ-027 With PARITY_EN, a PARITY state SHALL follow DATA and send the even-parity bit (XOR of the 8 latched bits) for OVERSAMPLE ticks, giving an 11-bit frame.

Verification
REQ-028 The bench SHALL cover: b_tick=1 constantly, fifo_empty=0, rdata=0x55 -> one fifo_pop, tx sequence 0,1,0,1,0,1,0,1,0,1 at 16 clks per bit, tx_done at clk 161 after the pop.
REQ-029 The bench SHALL cover: with PARITY_EN, rdata=0x55 -> parity bit 0; with rdata=0x07 -> parity bit 1; frame is 176 clks.
REQ-030 The bench SHALL cover: fifo_empty=1 for 50 clks -> fifo_pop=0, tx=1 and tx_busy=0 throughout.
REQ-031 The bench SHALL cover: three bytes 0xA1, 0x3C, 0xFF queued -> three pops, one idle clk between frames, and bytes decoded in order.
REQ-032 The bench SHALL cover: b_tick every 4th clk -> each bit lasts 64 clks and tick count freezes between strobes.
REQ-033 The bench SHALL cover: rst pulsed at clk 40 of the DATA phase -> tx=1 the same cycle, no tx_done, and the next pop follows the REQ-024 ordering.
